// File: rtl/instr_fetch_if.sv
// Fetch-unit bundle: instruction memory read port, decode handshake and branch redirect.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic [15:0] inop;
    logic        inop_valid;
    logic        inop_ready;
    logic [15:0] inop_pc;
    logic        redirect;
    logic [15:0] redirect_pc;

    modport master (
        output mem_addr, mem_rd, inop, inop_valid, inop_pc,
        input  mem_data, inop_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_addr, mem_rd, inop, inop_valid, inop_pc,
        output mem_data, inop_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch FSM presenting one registered instruction at a time to decode.
// Optional FETCH_PREFETCH_EN adds a one-entry prefetch buffer (2-cycle sustained rate).
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] inop_q;
    logic [15:0] inop_pc_q;
    logic        inop_valid_q;
    logic        mem_rd_q;
    logic [15:0] pc_inc;

`ifdef FETCH_PREFETCH_EN
    logic [15:0] pbuf_q;
    logic [15:0] pbuf_pc_q;
    logic        pbuf_valid_q;
    logic        ret_q;        // prefetch word is on mem_data this cycle
`endif

    assign pc_inc         = pc_q + 16'd1;
    assign bus.mem_addr   = pc_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.inop       = inop_q;
    assign bus.inop_pc    = inop_pc_q;
    assign bus.inop_valid = inop_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inop_q       <= '0;
            inop_pc_q    <= RESET_PC;
            inop_valid_q <= 1'b0;
            mem_rd_q     <= 1'b0;
`ifdef FETCH_PREFETCH_EN
            pbuf_q       <= '0;
            pbuf_pc_q    <= '0;
            pbuf_valid_q <= 1'b0;
            ret_q        <= 1'b0;
`endif
        end else if (bus.redirect) begin
            // A transfer in this cycle has already been consumed by decode; only the new stream matters.
            state_q      <= S_FETCH;
            pc_q         <= bus.redirect_pc;
            inop_valid_q <= 1'b0;
            mem_rd_q     <= 1'b1;
`ifdef FETCH_PREFETCH_EN
            pbuf_valid_q <= 1'b0;
            ret_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q  <= S_FETCH;
                    mem_rd_q <= 1'b1;
                end

                S_FETCH: begin
                    state_q  <= S_WAIT;
                    mem_rd_q <= 1'b0;
                end

                S_WAIT: begin
                    state_q      <= S_VALID;
                    inop_q       <= bus.mem_data;
                    inop_pc_q    <= pc_q;
                    pc_q         <= pc_inc;
                    inop_valid_q <= 1'b1;
`ifdef FETCH_PREFETCH_EN
                    mem_rd_q     <= 1'b1;
                    ret_q        <= 1'b0;
`endif
                end

                S_VALID: begin
`ifdef FETCH_PREFETCH_EN
                    ret_q    <= mem_rd_q;
                    mem_rd_q <= 1'b0;
                    if (bus.inop_ready) begin
                        if (pbuf_valid_q) begin
                            inop_q       <= pbuf_q;
                            inop_pc_q    <= pbuf_pc_q;
                            pbuf_valid_q <= 1'b0;
                            mem_rd_q     <= 1'b1;
                        end else if (ret_q) begin
                            // Returning prefetch word goes straight to decode, bypassing pbuf.
                            inop_q    <= bus.mem_data;
                            inop_pc_q <= pc_q;
                            pc_q      <= pc_inc;
                            mem_rd_q  <= 1'b1;
                        end else if (mem_rd_q) begin
                            inop_valid_q <= 1'b0;
                            state_q      <= S_WAIT;
                        end else begin
                            inop_valid_q <= 1'b0;
                            mem_rd_q     <= 1'b1;
                            state_q      <= S_FETCH;
                        end
                    end else begin
                        if (ret_q) begin
                            pbuf_q       <= bus.mem_data;
                            pbuf_pc_q    <= pc_q;
                            pc_q         <= pc_inc;
                            pbuf_valid_q <= 1'b1;
                        end else if (!pbuf_valid_q && !mem_rd_q) begin
                            mem_rd_q <= 1'b1;
                        end
                    end
`else
                    if (bus.inop_ready) begin
                        inop_valid_q <= 1'b0;
                        mem_rd_q     <= 1'b1;
                        state_q      <= S_FETCH;
                    end
`endif
                end

                default: begin
                    state_q      <= S_IDLE;
                    inop_valid_q <= 1'b0;
                    mem_rd_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed timing steps plus a randomized
// run checked against an address-stream reference model.
module tb_instr_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];

    // One-cycle read latency; garbage on the bus when no read was issued.
    always @(posedge clk) begin
        if (bus.mem_rd === 1'b1) bus.mem_data <= mem[bus.mem_addr];
        else                     bus.mem_data <= 16'($urandom);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next transfer; waits = cycles spent before it, -1 on timeout.
    task automatic take(output logic [15:0] d, output logic [15:0] pc, output int waits);
        bit done;
        done  = 1'b0;
        d     = '0;
        pc    = '0;
        waits = -1;
        for (int i = 0; i < 32 && !done; i++) begin
            if (bus.inop_valid === 1'b1 && bus.inop_ready === 1'b1) begin
                d     = bus.inop;
                pc    = bus.inop_pc;
                waits = i;
                done  = 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d, pc, exp_pc, held_d, held_pc, rpc;
        int          waits, n_xfer;
        bit          hold_pending, redir;

        rst             = 1'b0;
        bus.inop_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        for (int unsigned a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mem[0] = 16'h0102;

        // Reset state
        repeat (3) tick();
        chk("rst_valid", bus.inop_valid, 1'b0);
        chk("rst_inop", bus.inop, 16'h0000);
        chk("rst_inop_pc", bus.inop_pc, RESET_PC);
        chk("rst_mem_rd", bus.mem_rd, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, RESET_PC);

        // Release: read on the second edge, instruction valid after the third
        rst = 1'b1;
        chk("rel_rd", bus.mem_rd, 1'b0);
        tick();
        chk("e1_rd", bus.mem_rd, 1'b1);
        chk("e1_addr", bus.mem_addr, 16'h0000);
        tick();
        chk("e2_valid", bus.inop_valid, 1'b0);
        tick();
        chk("e3_valid", bus.inop_valid, 1'b1);
        chk("e3_inop", bus.inop, 16'h0102);
        chk("e3_inop_pc", bus.inop_pc, 16'h0000);

`ifndef FETCH_PREFETCH_EN
        // Decode stalls: instruction held, no further reads
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", bus.inop_valid, 1'b1);
            chk("hold_inop", bus.inop, 16'h0102);
            chk("hold_rd", bus.mem_rd, 1'b0);
            chk("hold_pc", bus.mem_addr, 16'h0001);
        end

        // Transfer, then redirect while the next word is returning
        bus.inop_ready = 1'b1;
        tick();
        chk("xf_valid", bus.inop_valid, 1'b0);
        chk("xf_rd", bus.mem_rd, 1'b1);
        chk("xf_addr", bus.mem_addr, 16'h0001);
        tick();
        chk("wait_rd", bus.mem_rd, 1'b0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        tick();
        bus.redirect = 1'b0;
        chk("rd40_valid", bus.inop_valid, 1'b0);
        chk("rd40_rd", bus.mem_rd, 1'b1);
        chk("rd40_addr", bus.mem_addr, 16'h0040);
        take(d, pc, waits);
        chk("rd40_to", (waits >= 0), 1'b1);
        chk("rd40_inop", d, mem[16'h0040]);
        chk("rd40_inop_pc", pc, 16'h0040);
`endif

        // Wrap of the program counter across 16'hFFFF
        bus.inop_ready  = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        tick();
        bus.redirect = 1'b0;
        exp_pc = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            take(d, pc, waits);
            chk("wrap_to", (waits >= 0), 1'b1);
            chk("wrap_pc", pc, exp_pc);
            chk("wrap_inop", d, mem[exp_pc]);
            exp_pc = exp_pc + 16'd1;
        end

        // Asynchronous reset while an instruction is valid
        bus.inop_ready = 1'b0;
        for (int i = 0; i < 20 && bus.inop_valid !== 1'b1; i++) tick();
        chk("ar_reach_valid", bus.inop_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", bus.inop_valid, 1'b0);
        chk("ar_inop", bus.inop, 16'h0000);
        chk("ar_inop_pc", bus.inop_pc, RESET_PC);
        chk("ar_addr", bus.mem_addr, RESET_PC);
        chk("ar_rd", bus.mem_rd, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("ar_rel_rd", bus.mem_rd, 1'b1);
        chk("ar_rel_addr", bus.mem_addr, RESET_PC);

`ifdef FETCH_PREFETCH_EN
        // Prefetch stream mem[n]=n: one transfer every 2 cycles, redirect flushes pbuf
        for (int unsigned a = 0; a < 16; a++) mem[a] = 16'(a);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.inop_ready = 1'b1;
        take(d, pc, waits);
        chk("pf_first", d, 16'h0000);
        for (int k = 1; k < 4; k++) begin
            take(d, pc, waits);
            chk("pf_inop", d, 32'(k));
            chk("pf_rate", waits, 32'd1);
        end
        bus.inop_ready = 1'b0;
        repeat (4) tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0008;
        tick();
        bus.redirect   = 1'b0;
        bus.inop_ready = 1'b1;
        take(d, pc, waits);
        chk("pf_flush_a", d, 16'h0008);
        take(d, pc, waits);
        chk("pf_flush_b", d, 16'h0009);
`endif

        // Randomized run against the address-stream model
        bus.inop_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_pc       = RESET_PC;
        n_xfer       = 0;
        hold_pending = 1'b0;
        held_d       = '0;
        held_pc      = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            redir = ($urandom_range(0, 31) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? (16'hFFFF - 16'($urandom_range(0, 2)))
                                                 : 16'($urandom);
            bus.inop_ready  = ($urandom_range(0, 3) != 0);
            bus.redirect    = redir;
            bus.redirect_pc = rpc;
            if (hold_pending) begin
                chk("rnd_hold_valid", bus.inop_valid, 1'b1);
                chk("rnd_hold_inop", bus.inop, held_d);
                chk("rnd_hold_pc", bus.inop_pc, held_pc);
            end
            if (bus.inop_valid === 1'b1 && bus.inop_ready) begin
                chk("rnd_pc", bus.inop_pc, exp_pc);
                chk("rnd_inop", bus.inop, mem[exp_pc]);
                exp_pc = exp_pc + 16'd1;
                n_xfer++;
            end
            if (redir) exp_pc = rpc;
            hold_pending = (bus.inop_valid === 1'b1) && !bus.inop_ready && !redir;
            held_d  = bus.inop;
            held_pc = bus.inop_pc;
            tick();
        end
        bus.redirect = 1'b0;
        chk("rnd_progress", (n_xfer > 100), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: program counter value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; acts on negedge rst, independent of clk.
REQ-004 mem_addr  output  16  instruction memory word address.
REQ-005 mem_rd  output  1  memory read strobe; data returns on mem_data exactly one cycle later.
REQ-006 mem_data  input  16  instruction word from memory, sampled the cycle after mem_rd.
REQ-007 inop  output  16  registered instruction word presented to the decode FSM.
REQ-008 inop_valid  output  1  inop holds a valid instruction.
REQ-009 inop_ready  input  1  decode FSM accepts inop this cycle.
REQ-010 inop_pc  output  16  address from which inop was fetched.
REQ-011 redirect  input  1  branch/jump taken; fetch restarts at redirect_pc.
REQ-012 redirect_pc  input  16  new fetch address, sampled when redirect=1.

Function
REQ-013 States: S_IDLE, S_FETCH, S_WAIT, S_VALID; encoded 2 bits.
REQ-014 S_IDLE: mem_rd=0; unconditional transition to S_FETCH next cycle.
REQ-015 S_FETCH: mem_rd=1, mem_addr=pc; transition to S_WAIT.
REQ-016 S_WAIT: mem_rd=0; inop<=mem_data, inop_pc<=pc, pc<=pc+1; transition to S_VALID.
REQ-017 S_VALID: inop_valid=1; inop and inop_pc held stable while inop_ready=0.
REQ-018 Transfer occurs on a cycle with inop_valid=1 and inop_ready=1; after transfer, S_VALID -> S_FETCH (base latency 3 cycles per instruction).
REQ-019 inop_valid is asserted only in S_VALID; inop_ready is ignored in all other states.
REQ-020 pc increments modulo 2^16: 16'hFFFF + 1 = 16'h0000, no flag.
REQ-021 redirect=1 in any state has priority over all other transitions: pc<=redirect_pc, next state S_FETCH, inop_valid=0 next cycle.
REQ-022 Data returning in the cycle after a redirect-cancelled read is discarded; it never reaches inop.
REQ-023 redirect and transfer in the same cycle: transfer completes (decode has consumed inop), then redirect applies as REQ-021.
REQ-024 mem_addr equals pc in all states; mem_rd is the only read qualifier.

Reset
REQ-025 While rst=0: state=S_IDLE, pc=RESET_PC, mem_rd=0, mem_addr=RESET_PC, inop=16'h0000, inop_valid=0, inop_pc=RESET_PC.
REQ-026 Reset asserted mid-operation aborts any fetch immediately; a pending mem_data return is ignored.
REQ-027 First mem_rd occurs on the second rising clk edge after rst deasserts (S_IDLE then S_FETCH).

Configuration
REQ-028 Macro FETCH_PREFETCH_EN enables a one-entry prefetch buffer (pbuf, pbuf_valid, pbuf_pc).
REQ-029 With FETCH_PREFETCH_EN: in S_VALID with pbuf_valid=0 and no read in flight, mem_rd=1 at pc; the returned word loads pbuf, pbuf_pc<=pc, pc<=pc+1.
REQ-030 With FETCH_PREFETCH_EN: on transfer with pbuf_valid=1, inop<=pbuf, inop_pc<=pbuf_pc, pbuf_valid<=0, state stays S_VALID (one instruction every 2 cycles sustained).
REQ-031 With FETCH_PREFETCH_EN: redirect clears pbuf_valid and discards any in-flight read; reset clears pbuf_valid=0, pbuf=16'h0000.
REQ-032 Without FETCH_PREFETCH_EN: no prefetch storage exists and behaviour is exactly REQ-013..REQ-024.

Verification
REQ-033 Reset release, RESET_PC=16'h0000, mem[0]=16'h0102, inop_ready=1 -> mem_rd at cycle 2 with addr 0; inop=16'h0102, inop_valid=1, inop_pc=0 at cycle 4.
REQ-034 inop_ready=0 for 5 cycles with inop=16'h0102 -> inop and inop_valid stable, no further mem_rd (prefetch off), pc=1.
REQ-035 redirect=1, redirect_pc=16'h0040 during S_WAIT -> stale word discarded; next inop is mem[0x40] with inop_pc=16'h0040.
REQ-036 redirect_pc=16'hFFFF, continuous ready -> inop_pc sequence 16'hFFFF, 16'h0000, 16'h0001.
REQ-037 rst pulled low in S_VALID -> inop_valid=0, inop=16'h0000, pc=RESET_PC asynchronously, before next clk edge.
REQ-038 FETCH_PREFETCH_EN defined, inop_ready=1, mem[n]=n -> inop values 0,1,2,3 with one transfer every 2 cycles after startup; redirect mid-stream flushes pbuf, no stale value appears.
